// File: rtl/video_pkg.sv
// Shared video types: framebuffer geometry, RGB565/RGB888 pixel formats and
// the front-buffer swap FSM encoding.
package video_pkg;

  localparam int FB_W = 1280 >> 2;
  localparam int FB_H = 720 >> 2;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    SWAP_IDLE,
    SWAP_PENDING,
    SWAP_WAIT_LOW
  } swap_state_t;

  // MSB replication keeps full-scale inputs at 8'hFF and zero at 8'h00.
  function automatic rgb888_t rgb565_to_rgb888(input rgb565_t p);
    rgb888_t c;
    c.r = {p.r, p.r[4:2]};
    c.g = {p.g, p.g[5:4]};
    c.b = {p.b, p.b[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Resettable shift register: delays a WIDTH-bit bundle by exactly DEPTH cycles.
// Reset clears every stage so no stale strobes emerge after a mid-frame reset.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: maps active pixel position to upscaled BRAM addresses,
// expands RGB565 to RGB888 and realigns strobes; swaps front buffer on frame edge.
module fb_scanout
  import video_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES    = 720,
  parameter int SCALE_SHIFT     = 2,
  parameter int READ_LATENCY    = 2,
  parameter int H_W             = 11,
  parameter int V_W             = 10,
  parameter int ADDR_W          = $clog2(2 * FB_W * FB_H)
) (
  input  logic              clk_pixel_in,
  input  logic              rst_in,
  input  logic [H_W-1:0]    hcount_in,
  input  logic [V_W-1:0]    vcount_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              ad_in,
  input  logic              nf_in,
  input  logic              swap_req_in,
  output logic              swap_ack_out,
  output logic              front_buf_out,
  output logic [ADDR_W-1:0] fb_addr_out,
  output logic              fb_rd_en_out,
  input  logic [15:0]       fb_data_in,
  output logic [7:0]        red_out,
  output logic [7:0]        green_out,
  output logic [7:0]        blue_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              ad_out,
  output logic              nf_out
);

  localparam int FB_W_L = ACTIVE_H_PIXELS >> SCALE_SHIFT;
  localparam int FB_H_L = ACTIVE_LINES >> SCALE_SHIFT;
  localparam int LAT    = READ_LATENCY + 2;

  localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(FB_W_L * FB_H_L);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(FB_W_L);

  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q;
  rgb565_t           pix_q;
  swap_state_t       state_q, state_d;
  logic              front_buf_q, front_buf_d;
  logic              ack_q, ack_d;
  logic              row_last;
  logic [ADDR_W-1:0] x_ext;
  logic [3:0]        strb_dly;
  rgb888_t           rgb;

  // Last column of the last source-line replica: step to the next fb row.
  assign row_last = (hcount_in == H_W'(ACTIVE_H_PIXELS - 1)) &&
                    (vcount_in < V_W'(ACTIVE_LINES)) &&
                    (&vcount_in[SCALE_SHIFT-1:0]);

  assign x_ext = ADDR_W'(hcount_in >> SCALE_SHIFT);

  always_comb begin
    row_base_d = row_base_q;
    if (nf_in) begin
      row_base_d = '0;
    end else if (row_last) begin
      row_base_d = row_base_q + ROW_STEP;
    end
  end

  always_comb begin
    addr_d = (front_buf_q ? BUF1_BASE : '0) + row_base_q + x_ext;
  end

  always_comb begin
    state_d     = state_q;
    front_buf_d = front_buf_q;
    ack_d       = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (swap_req_in) state_d = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (nf_in) begin
          front_buf_d = ~front_buf_q;
          ack_d       = 1'b1;
          state_d     = SWAP_WAIT_LOW;
        end
      end
      SWAP_WAIT_LOW: begin
        if (!swap_req_in) state_d = SWAP_IDLE;
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      row_base_q  <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      pix_q       <= '0;
      state_q     <= SWAP_IDLE;
      front_buf_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      row_base_q  <= row_base_d;
      addr_q      <= addr_d;
      rd_en_q     <= ad_in;
      pix_q       <= rgb565_t'(fb_data_in);
      state_q     <= state_d;
      front_buf_q <= front_buf_d;
      ack_q       <= ack_d;
    end
  end

  pipe_delay #(
    .WIDTH (4),
    .DEPTH (LAT)
  ) u_strb_dly (
    .clk_i  (clk_pixel_in),
    .rst_i  (rst_in),
    .din_i  ({hs_in, vs_in, ad_in, nf_in}),
    .dout_o (strb_dly)
  );

  assign {hs_out, vs_out, ad_out, nf_out} = strb_dly;

  assign rgb       = rgb565_to_rgb888(pix_q);
  assign red_out   = ad_out ? rgb.r : 8'h00;
  assign green_out = ad_out ? rgb.g : 8'h00;
  assign blue_out  = ad_out ? rgb.b : 8'h00;

  assign fb_addr_out   = addr_q;
  assign fb_rd_en_out  = rd_en_q;
  assign front_buf_out = front_buf_q;
  assign swap_ack_out  = ack_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: addressing, latency, colour expansion,
// buffer swap protocol and asynchronous reset, against hand-computed values.
module tb_fb_scanout;

  logic        clk;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hs, vs, ad, nf;
  logic        swap_req;
  logic        swap_ack;
  logic        front_buf;
  logic [16:0] fb_addr;
  logic        fb_rd_en;
  logic [15:0] fb_data;
  logic [7:0]  red, green, blue;
  logic        hs_o, vs_o, ad_o, nf_o;

  int n_checks = 0;
  int n_errors = 0;

  fb_scanout dut (
    .clk_pixel_in  (clk),
    .rst_in        (rst),
    .hcount_in     (hcount),
    .vcount_in     (vcount),
    .hs_in         (hs),
    .vs_in         (vs),
    .ad_in         (ad),
    .nf_in         (nf),
    .swap_req_in   (swap_req),
    .swap_ack_out  (swap_ack),
    .front_buf_out (front_buf),
    .fb_addr_out   (fb_addr),
    .fb_rd_en_out  (fb_rd_en),
    .fb_data_in    (fb_data),
    .red_out       (red),
    .green_out     (green),
    .blue_out      (blue),
    .hs_out        (hs_o),
    .vs_out        (vs_o),
    .ad_out        (ad_o),
    .nf_out        (nf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [47:0] all_outs = {fb_addr, fb_rd_en, red, green, blue,
                          hs_o, vs_o, ad_o, nf_o, swap_ack, front_buf};
  wire [3:0]  strobes  = {hs_o, vs_o, ad_o, nf_o};
  wire [23:0] colour   = {red, green, blue};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input logic a,
                       input logic n, input logic h_s, input logic v_s);
    hcount = 11'(h);
    vcount = 10'(v);
    ad     = a;
    nf     = n;
    hs     = h_s;
    vs     = v_s;
  endtask

  task automatic sweep_last_col(input int v_from, input int v_to);
    for (int v = v_from; v <= v_to; v++) begin
      drive(1279, v, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  logic [15:0] pat_in  [7];
  logic [23:0] pat_exp [7];

  initial begin
    pat_in[0] = 16'hF800; pat_exp[0] = 24'hFF0000;
    pat_in[1] = 16'h07E0; pat_exp[1] = 24'h00FF00;
    pat_in[2] = 16'h001F; pat_exp[2] = 24'h0000FF;
    pat_in[3] = 16'h8410; pat_exp[3] = 24'h848284;
    pat_in[4] = 16'hFFFF; pat_exp[4] = 24'hFFFFFF;
    pat_in[5] = 16'hA5A5; pat_exp[5] = 24'hA5B629;
    pat_in[6] = 16'h0000; pat_exp[6] = 24'h000000;

    rst = 1'b1;
    swap_req = 1'b0;
    fb_data = 16'h0000;
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("reset_outs", 64'(all_outs), 64'h0);
    rst = 1'b0;

    // Addressing, front buffer 0
    drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check("addr_0_0", 64'(fb_addr), 64'd0);
    check("rd_en_on", 64'(fb_rd_en), 64'd1);
    drive(4, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check("addr_4_0", 64'(fb_addr), 64'd1);
    drive(3, 3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check("addr_3_3", 64'(fb_addr), 64'd0);
    drive(5, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    check("rd_en_off", 64'(fb_rd_en), 64'd0);
    drive(1279, 3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check("addr_1279_3", 64'(fb_addr), 64'd319);
    drive(0, 4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check("addr_0_4", 64'(fb_addr), 64'd320);
    sweep_last_col(4, 719);
    check("addr_1279_719", 64'(fb_addr), 64'd57599);
    drive(0, 720, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check("row_base_clr", 64'(fb_addr), 64'd0);

    // Latency and strobe alignment
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    drive(8, 0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    check("lat_addr", 64'(fb_addr), 64'd2);
    check("lat_strb_c0", 64'(strobes), 64'h0);
    drive(9, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    check("lat_strb_c1", 64'(strobes), 64'h0);
    tick();
    check("lat_strb_c2", 64'(strobes), 64'h0);
    fb_data = 16'hF800;
    tick();
    check("lat_strb_c3", 64'(strobes), 64'hA);
    check("lat_colour", 64'(colour), 64'hFF0000);
    fb_data = 16'h0000;
    tick();
    check("lat_strb_c4", 64'(strobes), 64'h0);
    drive(0, 721, 1'b0, 1'b1, 1'b0, 1'b1); tick();
    drive(0, 721, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("lat_vs_nf", 64'(strobes), 64'h5);

    // Colour expansion with ad held high
    drive(16, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 7; i++) begin
      fb_data = pat_in[i];
      tick();
      check($sformatf("colour_%0h", pat_in[i]), 64'(colour), 64'(pat_exp[i]));
    end
    drive(16, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    fb_data = 16'hFFFF;
    for (int i = 0; i < 4; i++) tick();
    check("blank_ad_out", 64'(ad_o), 64'd0);
    check("blank_colour", 64'(colour), 64'h0);
    fb_data = 16'h0000;

    // Swap requested mid-frame
    drive(200, 100, 1'b1, 1'b0, 1'b0, 1'b0);
    swap_req = 1'b1;
    tick(); tick(); tick();
    check("swap_wait_buf", 64'(front_buf), 64'd0);
    check("swap_wait_ack", 64'(swap_ack), 64'd0);
    drive(0, 725, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    check("swap1_buf", 64'(front_buf), 64'd1);
    check("swap1_ack", 64'(swap_ack), 64'd1);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    check("swap1_ack_end", 64'(swap_ack), 64'd0);
    sweep_last_col(0, 719);
    check("addr_buf1_last", 64'(fb_addr), 64'd115199);

    // Request held through three frames
    for (int f = 0; f < 3; f++) begin
      drive(0, 725, 1'b0, 1'b1, 1'b0, 1'b0); tick();
      check($sformatf("held_ack_%0d", f), 64'(swap_ack), 64'd0);
      check($sformatf("held_buf_%0d", f), 64'(front_buf), 64'd1);
      drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick(); tick();
    end
    swap_req = 1'b0; tick();
    swap_req = 1'b1; tick();
    check("swap2_pre_buf", 64'(front_buf), 64'd1);
    drive(0, 725, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    check("swap2_buf", 64'(front_buf), 64'd0);
    check("swap2_ack", 64'(swap_ack), 64'd1);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    swap_req = 1'b0;
    tick(); tick();

    // Request rising on the nf cycle is served one frame later
    swap_req = 1'b1;
    drive(0, 725, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    check("same_nf_buf", 64'(front_buf), 64'd0);
    check("same_nf_ack", 64'(swap_ack), 64'd0);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick(); tick();
    drive(0, 725, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    check("next_nf_buf", 64'(front_buf), 64'd1);
    check("next_nf_ack", 64'(swap_ack), 64'd1);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    swap_req = 1'b0;
    tick(); tick();

    // Asynchronous reset mid-line
    drive(100, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    fb_data = 16'hFFFF;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_red", 64'(red), 64'hFF);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_outs", 64'(all_outs), 64'h0);
    tick();
    rst = 1'b0;
    drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("post_rst_addr", 64'(fb_addr), 64'd0);
    check("post_rst_rd_en", 64'(fb_rd_en), 64'd1);
    check("post_rst_black0", 64'(colour), 64'h0);
    tick(); tick();
    check("post_rst_black2", 64'(colour), 64'h0);
    tick();
    check("post_rst_first_px", 64'(colour), 64'hFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
